// File: rtl/p_hardisc.sv
// Shared definitions for the hardisc core and its bus peripherals:
// timer register offsets, AHB-Lite encodings and the data-bus checksum.
package p_hardisc;

  // Machine timer register offsets (byte offsets inside the 32-byte window)
  localparam logic [4:0] TMR_MTIME_LO = 5'h00;
  localparam logic [4:0] TMR_MTIME_HI = 5'h04;
  localparam logic [4:0] TMR_CMP_LO   = 5'h08;
  localparam logic [4:0] TMR_CMP_HI   = 5'h0C;
  localparam logic [4:0] TMR_CTRL     = 5'h10;
  localparam logic [4:0] TMR_END      = 5'h14;

  // AHB-Lite transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB-Lite transfer sizes
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // SECDED (39,32) check bits. Data bits occupy the Hamming positions 1..38
  // that are not powers of two (3,5,6,7,9,...). Check bit k is the parity of
  // every data bit whose position has bit k set; bit 6 is the overall parity
  // of data and the six Hamming bits.
  function automatic logic [6:0] secded_encode(input logic [31:0] data);
    logic [6:0] chk;
    int         j;
    chk = '0;
    j   = 0;
    for (int pos = 1; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int k = 0; k < 6; k++) begin
          if (((pos >> k) & 1) == 1) chk[k] = chk[k] ^ data[j];
        end
        j = j + 1;
      end
    end
    chk[6] = (^data) ^ (^chk[5:0]);
    return chk;
  endfunction

endpackage

// File: rtl/ahb_timer.sv
// Machine timer on the AHB-Lite data bus: 64-bit mtime with prescaler,
// 64-bit mtimecmp, control register and the level timer interrupt.
// Valid/ready contract: a transfer is taken when hsel & htrans[1] & hready are
// high at a clock edge; legal transfers complete with zero wait states, illegal
// ones get the two-cycle ERROR response (hreadyout low then high, hresp high).
module ahb_timer
  import p_hardisc::*;
#(
  parameter int          PRESC_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [31:0] s_hwdata_i,
  input  logic        s_hready_i,
  output logic [31:0] s_hrdata_o,
  output logic [6:0]  s_hrchecksum_o,
  output logic        s_hreadyout_o,
  output logic        s_hresp_o,
  output logic        s_int_mtip_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  // Selection comes from hsel; the base address and upper address bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^{BASE_ADDR, s_haddr_i[31:5], s_htrans_i[0]};

  logic [4:0]         addr_off;
  logic               accept;
  logic               addr_err;
  logic               dp_valid, dp_write, dp_err;
  logic [4:0]         dp_off;
  logic               wr_en;
  logic [1:0]         state, state_next;
  logic [63:0]        mtime, mtimecmp;
  logic               ctrl_en;
  logic [PRESC_W-1:0] ctrl_presc, pcnt;
  logic               tick;
  logic [31:0]        rd_val, ctrl_rd;

  assign addr_off = s_haddr_i[4:0];
  assign accept   = s_hsel_i & s_htrans_i[1] & s_hready_i;
  assign addr_err = (s_hsize_i != HSIZE_WORD) | (addr_off[1:0] != 2'b00) |
                    (addr_off >= TMR_END);
  assign wr_en    = dp_valid & dp_write & ~dp_err;
  assign tick     = ctrl_en & (pcnt == ctrl_presc);

  // Address-phase capture of the transfer attributes for the data phase
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
      dp_err   <= 1'b0;
    end else begin
      dp_valid <= accept;
      if (accept) begin
        dp_write <= s_hwrite_i;
        dp_off   <= addr_off;
        dp_err   <= addr_err;
      end
    end
  end

  // Error-response state: IDLE for legal traffic, ERR1/ERR2 for the two error cycles
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && addr_err) state_next = ST_ERR1;
      ST_ERR1: state_next = ST_ERR2;
      ST_ERR2: state_next = (accept && addr_err) ? ST_ERR1 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Error-response state register
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) state <= ST_IDLE;
    else             state <= state_next;
  end

  assign s_hreadyout_o = (state != ST_ERR1);
  assign s_hresp_o     = (state != ST_IDLE);

  // Register read mux; values are the ones held before this edge's updates
  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[0]             = ctrl_en;
    ctrl_rd[8 +: PRESC_W]  = ctrl_presc;
    rd_val                 = '0;
    case (addr_off)
      TMR_MTIME_LO: rd_val = mtime[31:0];
      TMR_MTIME_HI: rd_val = mtime[63:32];
      TMR_CMP_LO:   rd_val = mtimecmp[31:0];
      TMR_CMP_HI:   rd_val = mtimecmp[63:32];
      TMR_CTRL:     rd_val = ctrl_rd;
      default:      rd_val = '0;
    endcase
  end

  // Read data and its checksum are captured at the accepting edge and held
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      s_hrdata_o     <= '0;
      s_hrchecksum_o <= secded_encode(32'h0);
    end else if (accept && !s_hwrite_i && !addr_err) begin
      s_hrdata_o     <= rd_val;
      s_hrchecksum_o <= secded_encode(rd_val);
    end
  end

  // Control register and prescaler counter; a CTRL write restarts the prescale period
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      ctrl_en    <= 1'b1;
      ctrl_presc <= '0;
      pcnt       <= '0;
    end else if (wr_en && dp_off == TMR_CTRL) begin
      ctrl_en    <= s_hwdata_i[0];
      ctrl_presc <= s_hwdata_i[8 +: PRESC_W];
      pcnt       <= '0;
    end else if (ctrl_en) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

  // mtime: a software write to either half wins over the increment in that cycle
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i)                               mtime <= '0;
    else if (wr_en && dp_off == TMR_MTIME_LO)      mtime <= {mtime[63:32], s_hwdata_i};
    else if (wr_en && dp_off == TMR_MTIME_HI)      mtime <= {s_hwdata_i, mtime[31:0]};
    else if (tick)                                 mtime <= mtime + 64'd1;
  end

  // mtimecmp halves are written independently
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i)                               mtimecmp <= '1;
    else if (wr_en && dp_off == TMR_CMP_LO)        mtimecmp[31:0]  <= s_hwdata_i;
    else if (wr_en && dp_off == TMR_CMP_HI)        mtimecmp[63:32] <= s_hwdata_i;
  end

  // Registered level interrupt from the unsigned 64-bit compare
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) s_int_mtip_o <= 1'b0;
    else             s_int_mtip_o <= (mtime >= mtimecmp);
  end

endmodule
